// File: rtl/spi_slave_checker.sv
// spi_slave_checker
//   Passive on-line protocol checker for the SPI slave. Watches the serial
//   pins plus the slave's rx/tx handshake and flags four error classes:
//     0 RX_MISMATCH    rx_data differs from the last FRAME_W MOSI samples
//     1 TX_MISMATCH    MISO differs from the bit expected from tx_data
//     2 IDLE_VIOLATION MISO/rx_valid/tx_valid high SS_QUIET cycles after SS_n high
//     3 CMD_PATTERN    second MOSI bit of a frame differs from the first
//   Build option: define SPI_CHK_COUNTERS_EN to build per-class saturating
//   error counters; otherwise err_cnt is tied to 0.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   SS_n, MOSI, MISO  observed serial pins
//   rx_valid/rx_data  observed received-word strobe and word
//   tx_valid/tx_data  observed reply-load strobe and word
//   clr               synchronous clear of sticky/first/counter state
//   err_pulse         one-cycle flag per class
//   err_sticky        OR of err_pulse since rst/clr
//   first_err         0 none, else 1 + lowest class of the first error event
//   frame_cnt         saturating count of rx_valid rises (cleared only by rst)
//   err_cnt           per-class saturating counters, class k at [k*CNT_W +: CNT_W]
module spi_slave_checker #(
  parameter int FRAME_W  = 10,
  parameter int TX_W     = 8,
  parameter int SS_QUIET = 2,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic                 MISO,
  input  logic                 rx_valid,
  input  logic [FRAME_W-1:0]   rx_data,
  input  logic                 tx_valid,
  input  logic [TX_W-1:0]      tx_data,
  input  logic                 clr,
  output logic [3:0]           err_pulse,
  output logic [3:0]           err_sticky,
  output logic [2:0]           first_err,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [4*CNT_W-1:0]   err_cnt
);

  localparam int IDX_W = (TX_W > 1) ? $clog2(TX_W) : 1;

  typedef enum logic       {TX_IDLE, TX_RUN}          tx_state_t;
  typedef enum logic [1:0] {CP_IDLE, CP_CAP, CP_CMP}  cp_state_t;

  tx_state_t           tx_st;
  cp_state_t           cp_st;
  logic [FRAME_W-1:0]  mosi_hist;
  logic [SS_QUIET-1:0] ss_hist;     // [0] = SS_n last cycle, [SS_QUIET-1] oldest
  logic                rxv_q, txv_q;
  logic [TX_W-1:0]     tx_cap;
  logic [IDX_W-1:0]    tx_idx;
  logic                cp_b0;

  logic                rx_rise, tx_rise, ss_fall;
  logic [3:0]          det;
  logic [2:0]          first_det;

  assign rx_rise = rx_valid & ~rxv_q;
  assign tx_rise = tx_valid & ~txv_q;
  assign ss_fall = ~SS_n & ss_hist[0];

  always_comb begin
    det = '0;
    det[0] = rx_rise && (rx_data != mosi_hist);
    // A restart or a deselect in TX_RUN suppresses the compare that cycle.
    det[1] = (tx_st == TX_RUN) && !tx_rise && !SS_n && (MISO != tx_cap[tx_idx]);
    det[2] = ss_hist[SS_QUIET-1] && (MISO || rx_valid || tx_valid);
    det[3] = (cp_st == CP_CMP) && !SS_n && (MOSI != cp_b0);
  end

  // Lowest class wins when several fire together.
  always_comb begin
    first_det = 3'd0;
    if      (det[0]) first_det = 3'd1;
    else if (det[1]) first_det = 3'd2;
    else if (det[2]) first_det = 3'd3;
    else if (det[3]) first_det = 3'd4;
  end

  // Edge-detect copies and histories.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_hist <= '0;
      ss_hist   <= '0;
      rxv_q     <= 1'b0;
      txv_q     <= 1'b0;
    end else begin
      mosi_hist  <= {mosi_hist[FRAME_W-2:0], MOSI};
      ss_hist[0] <= SS_n;
      for (int i = 1; i < SS_QUIET; i++) ss_hist[i] <= ss_hist[i-1];
      rxv_q      <= rx_valid;
      txv_q      <= tx_valid;
    end
  end

  // TX reply FSM: walks the captured word MSB first, one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_cap <= '0;
      tx_idx <= '0;
    end else if (tx_rise) begin
      tx_st  <= TX_RUN;
      tx_cap <= tx_data;
      tx_idx <= IDX_W'(TX_W - 1);
    end else if (tx_st == TX_RUN) begin
      if (SS_n || tx_idx == '0) tx_st <= TX_IDLE;
      else                      tx_idx <= tx_idx - 1'b1;
    end
  end

  // Command-pattern FSM: first two MOSI bits after select must match.
  always_ff @(posedge clk) begin
    if (rst) begin
      cp_st <= CP_IDLE;
      cp_b0 <= 1'b0;
    end else begin
      unique case (cp_st)
        CP_IDLE: if (ss_fall) cp_st <= CP_CAP;
        CP_CAP: begin
          if (SS_n) cp_st <= CP_IDLE;
          else begin
            cp_b0 <= MOSI;
            cp_st <= CP_CMP;
          end
        end
        CP_CMP:  cp_st <= CP_IDLE;
        default: cp_st <= CP_IDLE;
      endcase
    end
  end

  // Reporting. A detection in the same cycle as clr lands after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      first_err  <= '0;
      frame_cnt  <= '0;
    end else begin
      err_pulse  <= det;
      err_sticky <= (clr ? 4'b0000 : err_sticky) | det;
      if (clr || first_err == 3'd0) first_err <= first_det;
      if (rx_rise && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef SPI_CHK_COUNTERS_EN
  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (clr)                       cnt[k] <= det[k] ? CNT_W'(1) : '0;
        else if (det[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  assign err_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_checker.sv
// Directed bench for spi_slave_checker. Inputs change 1 time unit after each
// rising edge; outputs are checked at the same point, i.e. they show what the
// checker registered at the preceding edge.
module tb_spi_slave_checker;
  localparam int FW = 10;
  localparam int TW = 8;
  localparam int SQ = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SS_n = 1'b1, MOSI = 1'b0, MISO = 1'b0;
  logic          rx_valid = 1'b0, tx_valid = 1'b0, clr = 1'b0;
  logic [FW-1:0] rx_data = '0;
  logic [TW-1:0] tx_data = '0;
  logic [3:0]    err_pulse, err_sticky;
  logic [2:0]    first_err;
  logic [CW-1:0] frame_cnt;
  logic [4*CW-1:0] err_cnt;

  int checks = 0;
  int fails  = 0;

  logic [FW-1:0] pat = 10'b0011010101;
  logic [TW-1:0] txw = 8'hA5;
  logic [31:0]   cnt_exp;

  spi_slave_checker #(.FRAME_W(FW), .TX_W(TW), .SS_QUIET(SQ), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .clr(clr), .err_pulse(err_pulse), .err_sticky(err_sticky), .first_err(first_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic shift_pat();
    for (int i = FW-1; i >= 0; i--) begin
      MOSI = pat[i];
      step();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    chk("clr_first",  32'(first_err),  32'h0);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_pulse",  32'(err_pulse),  32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_first",  32'(first_err),  32'h0);
    chk("rst_frame",  32'(frame_cnt),  32'h0);
    chk("rst_cnt",    32'(err_cnt),    32'h0);
    rst = 1'b0;
    step(); step(); step();

    // RX check: matching then mismatching word
    SS_n = 1'b0; MOSI = 1'b0;
    step();
    shift_pat();
    rx_valid = 1'b1; rx_data = 10'h0D5;
    step();
    chk("rx_ok_pulse", 32'(err_pulse), 32'h0);
    chk("rx_ok_frame", 32'(frame_cnt), 32'h1);
    rx_valid = 1'b0;
    shift_pat();
    rx_valid = 1'b1; rx_data = 10'h0D4;
    step();
    chk("rx_bad_pulse",  32'(err_pulse),  32'h1);
    chk("rx_bad_first",  32'(first_err),  32'h1);
    chk("rx_bad_sticky", 32'(err_sticky), 32'h1);
    chk("rx_bad_frame",  32'(frame_cnt),  32'h2);
    rx_valid = 1'b0;
    step();
    chk("rx_pulse_once", 32'(err_pulse), 32'h0);
    chk("rx_sticky_hold", 32'(err_sticky), 32'h1);
    do_clr();

    // TX check: clean reply, then bit 4 flipped
    tx_valid = 1'b1; tx_data = 8'hA5; MISO = 1'b0;
    step();
    tx_valid = 1'b0;
    for (int i = TW-1; i >= 0; i--) begin
      MISO = txw[i];
      step();
      chk("tx_ok", 32'(err_pulse), 32'h0);
    end
    MISO = 1'b0; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = TW-1; i >= 0; i--) begin
      MISO = txw[i] ^ (i == 4);
      step();
      chk("tx_flip", 32'(err_pulse), (i == 4) ? 32'h2 : 32'h0);
    end
    MISO = 1'b0;
    chk("tx_sticky", 32'(err_sticky), 32'h2);
    chk("tx_first",  32'(first_err),  32'h2);
    do_clr();

    // Idle check: MISO held after deselect
    SS_n = 1'b1; MISO = 1'b1;
    step(); chk("idle_r0", 32'(err_pulse), 32'h0);
    step(); chk("idle_r1", 32'(err_pulse), 32'h0);
    step(); chk("idle_miso", 32'(err_pulse), 32'h4);
    MISO = 1'b0;
    step(); chk("idle_once", 32'(err_pulse), 32'h0);
    // Idle check: tx_valid pulse at rise+2 (TX FSM must abort silently)
    SS_n = 1'b0;
    step(); step(); step();
    do_clr();
    SS_n = 1'b1;
    step(); step();
    tx_valid = 1'b1;
    step(); chk("idle_txv", 32'(err_pulse), 32'h4);
    tx_valid = 1'b0;
    step(); chk("idle_tx_abort0", 32'(err_pulse), 32'h0);
    step(); chk("idle_tx_abort1", 32'(err_pulse), 32'h0);
    chk("idle_sticky", 32'(err_sticky), 32'h4);
    chk("idle_first",  32'(first_err),  32'h3);
    do_clr();

    // Command pattern: 0 then 1 flags, 1,1 passes, deselect in CMP aborts
    SS_n = 1'b0;
    step();
    MOSI = 1'b0; step();
    MOSI = 1'b1; step();
    chk("cp_bad_pulse", 32'(err_pulse), 32'h8);
    chk("cp_bad_first", 32'(first_err), 32'h4);
    step(); chk("cp_once", 32'(err_pulse), 32'h0);
    SS_n = 1'b1; step(); step(); step();
    SS_n = 1'b0; step();
    MOSI = 1'b1; step();
    MOSI = 1'b1; step();
    chk("cp_same", 32'(err_pulse), 32'h0);
    SS_n = 1'b1; step(); step(); step();
    SS_n = 1'b0; step();
    MOSI = 1'b0; step();
    SS_n = 1'b1; MOSI = 1'b1; step();
    chk("cp_abort0", 32'(err_pulse), 32'h0);
    step(); chk("cp_abort1", 32'(err_pulse), 32'h0);
    chk("cp_sticky", 32'(err_sticky), 32'h8);

    // Classes 0 and 3 together, then clr with a new class-2 error
    MOSI = 1'b0;
    repeat (12) step();
    do_clr();
    SS_n = 1'b0; step();
    step();
    MOSI = 1'b1; rx_valid = 1'b1; rx_data = 10'h001;
    step();
    chk("multi_pulse",  32'(err_pulse),  32'h9);
    chk("multi_first",  32'(first_err),  32'h1);
    chk("multi_sticky", 32'(err_sticky), 32'h9);
    chk("frame_sat3",   32'(frame_cnt),  32'h3);
    rx_valid = 1'b0; MOSI = 1'b0;
    step();
    SS_n = 1'b1; step(); step();
    MISO = 1'b1; clr = 1'b1;
    step();
    chk("clr_win_pulse",  32'(err_pulse),  32'h4);
    chk("clr_win_sticky", 32'(err_sticky), 32'h4);
    chk("clr_win_first",  32'(first_err),  32'h3);
    clr = 1'b0; MISO = 1'b0;
    step();

    // Counters: five class-0 errors saturate a 2-bit counter
    SS_n = 1'b0; step(); step(); step();
    do_clr();
    repeat (5) begin
      rx_valid = 1'b1; rx_data = 10'h3FF;
      step();
      rx_valid = 1'b0;
      step();
    end
`ifdef SPI_CHK_COUNTERS_EN
    cnt_exp = 32'h3;
`else
    cnt_exp = 32'h0;
`endif
    chk("cnt_sat",       32'(err_cnt),    cnt_exp);
    chk("frame_sat_hold", 32'(frame_cnt), 32'h3);
    chk("cnt_sticky",    32'(err_sticky), 32'h1);
    do_clr();
    chk("cnt_clr", 32'(err_cnt), 32'h0);

    // Reset in TX_RUN abandons the reply
    tx_valid = 1'b1; tx_data = 8'hFF; MISO = 1'b0;
    step();
    tx_valid = 1'b0; MISO = 1'b1;
    step();
    chk("txr_bit7", 32'(err_pulse), 32'h0);
    rst = 1'b1; MISO = 1'b0;
    step();
    chk("mid_rst_pulse",  32'(err_pulse),  32'h0);
    chk("mid_rst_sticky", 32'(err_sticky), 32'h0);
    chk("mid_rst_first",  32'(first_err),  32'h0);
    chk("mid_rst_frame",  32'(frame_cnt),  32'h0);
    chk("mid_rst_cnt",    32'(err_cnt),    32'h0);
    rst = 1'b0;
    step(); chk("post_rst0", 32'(err_pulse), 32'h0);
    step(); chk("post_rst1", 32'(err_pulse), 32'h0);
    step(); chk("post_rst_sticky", 32'(err_sticky), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
